// File: rtl/fetch_decode_reg.sv
// fetch_decode_reg: Fetch->Decode pipeline register with a one-entry skid
// buffer. The skid catches the word that the 1-cycle-latency IMEM returns
// while Decode is stalled, so nothing is lost when the stall releases.
// Saturating stall/flush/bubble counters are exposed for hazard-unit debug.
module fetch_decode_reg #(
   parameter logic [31:0] NOP   = 32'h00000013,
   parameter int          CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             StallD,
   input  logic             FlushD,
   input  logic [31:0]      InstrF,
   input  logic [31:0]      PCF,
   input  logic [31:0]      PCPlus4F,
   input  logic             ValidF,
   output logic             ReadyF,
   output logic [31:0]      InstrD,
   output logic [31:0]      PCD,
   output logic [31:0]      PCPlus4D,
   output logic             ValidD,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt,
   output logic [CNT_W-1:0] BubbleCnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Decode register
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      pc4_q, pc4_d;
   logic             valid_q, valid_d;

   // Skid entry (contents meaningless while sk_full_q is low)
   logic [31:0]      sk_instr_q, sk_instr_d;
   logic [31:0]      sk_pc_q, sk_pc_d;
   logic [31:0]      sk_pc4_q, sk_pc4_d;
   logic             sk_full_q, sk_full_d;

   // Debug counters
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   // Decoded cycle type
   logic             is_flush;
   logic             is_stall;
   logic             is_advance;
   logic             load_bubble;

   // ReadyF must not look at ValidF, otherwise fetch and this block could
   // form a combinational loop through the valid/ready handshake.
   assign ReadyF = FlushD | ~StallD | ~sk_full_q;

   // Classify the current cycle; flush outranks stall.
   always_comb begin
      is_flush    = FlushD;
      is_stall    = ~FlushD & StallD;
      is_advance  = ~FlushD & ~StallD;
      load_bubble = is_advance & ~sk_full_q & ~ValidF;
   end

   // Next state of the Decode register and the skid entry.
   always_comb begin
      instr_d    = instr_q;
      pc_d       = pc_q;
      pc4_d      = pc4_q;
      valid_d    = valid_q;
      sk_instr_d = sk_instr_q;
      sk_pc_d    = sk_pc_q;
      sk_pc4_d   = sk_pc4_q;
      sk_full_d  = sk_full_q;

      if (is_flush) begin
         instr_d   = NOP;
         pc_d      = '0;
         pc4_d     = '0;
         valid_d   = 1'b0;
         sk_full_d = 1'b0;
      end else if (is_stall) begin
         // Decode holds; an empty skid absorbs the word IMEM just returned.
         if (!sk_full_q && ValidF) begin
            sk_instr_d = InstrF;
            sk_pc_d    = PCF;
            sk_pc4_d   = PCPlus4F;
            sk_full_d  = 1'b1;
         end
      end else if (sk_full_q) begin
         // Older word lives in the skid, so it goes to Decode first and the
         // incoming word takes its place to preserve program order.
         instr_d = sk_instr_q;
         pc_d    = sk_pc_q;
         pc4_d   = sk_pc4_q;
         valid_d = 1'b1;
         if (ValidF) begin
            sk_instr_d = InstrF;
            sk_pc_d    = PCF;
            sk_pc4_d   = PCPlus4F;
         end else begin
            sk_full_d  = 1'b0;
         end
      end else if (ValidF) begin
         instr_d = InstrF;
         pc_d    = PCF;
         pc4_d   = PCPlus4F;
         valid_d = 1'b1;
      end else begin
         instr_d = NOP;
         pc_d    = '0;
         pc4_d   = '0;
         valid_d = 1'b0;
      end
   end

   // Saturating event counters: stop at all-ones rather than wrap.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (is_stall && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (is_flush && !(&flush_cnt_q)) begin
         flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
      if (load_bubble && !(&bubble_cnt_q)) begin
         bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end
   end

   // State registers; reset puts a NOP bubble in Decode and empties the skid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q      <= NOP;
         pc_q         <= '0;
         pc4_q        <= '0;
         valid_q      <= 1'b0;
         sk_instr_q   <= '0;
         sk_pc_q      <= '0;
         sk_pc4_q     <= '0;
         sk_full_q    <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         instr_q      <= instr_d;
         pc_q         <= pc_d;
         pc4_q        <= pc4_d;
         valid_q      <= valid_d;
         sk_instr_q   <= sk_instr_d;
         sk_pc_q      <= sk_pc_d;
         sk_pc4_q     <= sk_pc4_d;
         sk_full_q    <= sk_full_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   // Output drive straight from the registers.
   always_comb begin
      InstrD    = instr_q;
      PCD       = pc_q;
      PCPlus4D  = pc4_q;
      ValidD    = valid_q;
      StallCnt  = stall_cnt_q;
      FlushCnt  = flush_cnt_q;
      BubbleCnt = bubble_cnt_q;
   end

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Bench for fetch_decode_reg. A queue holds words accepted into the skid
// but not yet delivered to Decode; expected Decode contents and counters
// come from a behavioural model driven by the same stimulus.
module tb_fetch_decode_reg;

   localparam int          CW  = 4;
   localparam logic [31:0] NOP = 32'h00000013;
   localparam int          CMAX = (1 << CW) - 1;

   logic          clk, rst_n;
   logic          StallD, FlushD, ValidF, ReadyF, ValidD;
   logic [31:0]   InstrF, PCF, PCPlus4F, InstrD, PCD, PCPlus4D;
   logic [CW-1:0] StallCnt, FlushCnt, BubbleCnt;

   fetch_decode_reg #(.NOP(NOP), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .StallD(StallD), .FlushD(FlushD),
      .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF),
      .ReadyF(ReadyF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .ValidD(ValidD), .StallCnt(StallCnt), .FlushCnt(FlushCnt),
      .BubbleCnt(BubbleCnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } word_t;

   word_t       sk_q[$];
   logic [31:0] m_instr, m_pc, m_pc4;
   logic        m_valid;
   int          m_sc, m_fc, m_bc;
   logic [31:0] f_pc;
   logic        hold_q;
   int          n_chk, n_pass;

   function automatic logic [31:0] mk_instr(input logic [31:0] pc);
      return (pc << 5) ^ 32'h5A5A_0033;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_instr = NOP; m_pc = '0; m_pc4 = '0; m_valid = 1'b0;
      m_sc = 0; m_fc = 0; m_bc = 0;
      sk_q.delete();
      hold_q = 1'b0;
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, ".InstrD"},   InstrD,   m_instr);
      chk({tag, ".PCD"},      PCD,      m_pc);
      chk({tag, ".PCPlus4D"}, PCPlus4D, m_pc4);
      chk({tag, ".ValidD"},   32'(ValidD),    32'(m_valid));
      chk({tag, ".StallCnt"}, 32'(StallCnt),  32'(m_sc));
      chk({tag, ".FlushCnt"}, 32'(FlushCnt),  32'(m_fc));
      chk({tag, ".BubbleCnt"},32'(BubbleCnt), 32'(m_bc));
   endtask

   // One clock cycle: drive at negedge, check ReadyF, step model at posedge,
   // then check registered outputs just after the edge.
   task automatic cyc(input string tag, input logic st, input logic fl, input logic vf_in);
      logic  vf, rdy, acc;
      word_t w;
      @(negedge clk);
      vf = vf_in | hold_q;
      StallD = st; FlushD = fl; ValidF = vf;
      PCF = f_pc; InstrF = mk_instr(f_pc); PCPlus4F = f_pc + 32'd4;
      w.instr = InstrF; w.pc = PCF; w.pc4 = PCPlus4F;
      #1;
      rdy = fl | ~st | (sk_q.size() == 0);
      chk({tag, ".ReadyF"}, 32'(ReadyF), 32'(rdy));
      @(posedge clk);
      acc = vf & rdy & ~fl;
      if (fl) begin
         m_instr = NOP; m_pc = '0; m_pc4 = '0; m_valid = 1'b0;
         sk_q.delete();
         if (m_fc < CMAX) m_fc++;
      end else if (st) begin
         if (sk_q.size() == 0 && vf) sk_q.push_back(w);
         if (m_sc < CMAX) m_sc++;
      end else if (sk_q.size() != 0) begin
         word_t o;
         o = sk_q.pop_front();
         m_instr = o.instr; m_pc = o.pc; m_pc4 = o.pc4; m_valid = 1'b1;
         if (vf) sk_q.push_back(w);
      end else if (vf) begin
         m_instr = w.instr; m_pc = w.pc; m_pc4 = w.pc4; m_valid = 1'b1;
      end else begin
         m_instr = NOP; m_pc = '0; m_pc4 = '0; m_valid = 1'b0;
         if (m_bc < CMAX) m_bc++;
      end
      hold_q = vf & ~rdy;
      if (acc || (fl && vf)) f_pc = f_pc + 32'd4;
      #1;
      chk_outputs(tag);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".InstrD"},   InstrD,   NOP);
      chk({tag, ".PCD"},      PCD,      32'h0);
      chk({tag, ".PCPlus4D"}, PCPlus4D, 32'h0);
      chk({tag, ".ValidD"},   32'(ValidD),    32'h0);
      chk({tag, ".StallCnt"}, 32'(StallCnt),  32'h0);
      chk({tag, ".FlushCnt"}, 32'(FlushCnt),  32'h0);
      chk({tag, ".BubbleCnt"},32'(BubbleCnt), 32'h0);
      chk({tag, ".ReadyF"},   32'(ReadyF),    32'h1);
   endtask

   // Release reset shortly after a rising edge so the next cycle's stimulus
   // is applied before the first active edge out of reset.
   task automatic release_reset(input logic st, input logic fl);
      StallD = st; FlushD = fl; ValidF = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      rst_n = 1'b1; StallD = 1'b0; FlushD = 1'b0; ValidF = 1'b0;
      InstrF = '0; PCF = '0; PCPlus4F = '0;
      f_pc = 32'h0;
      model_reset();

      #3 rst_n = 1'b0;
      #1 chk_reset_state("por");
      release_reset(1'b1, 1'b0);

      // Stream 0x0, 0x4, 0x8 with no stall, then a 1-cycle stall with
      // PCD=0x4 and PCF=0x8 that routes 0x8 through the skid.
      cyc("stream0", 0, 0, 1);
      cyc("stream1", 0, 0, 1);
      chk("stall.pre_pcd", PCD, 32'h4);
      cyc("stall1", 1, 0, 1);
      chk("stall.hold_pcd", PCD, 32'h4);
      cyc("skid_out", 0, 0, 1);
      chk("skid.pcd8", PCD, 32'h8);
      cyc("skid_next", 0, 0, 1);
      chk("skid.pcdC", PCD, 32'hC);
      cyc("drain", 0, 0, 0);
      cyc("idle", 0, 0, 0);

      // Back-pressure: 3-cycle stall, skid fills on the first cycle.
      cyc("bp1", 1, 0, 1);
      cyc("bp2", 1, 0, 1);
      chk("bp2.ReadyF_low", 32'(ReadyF), 32'h0);
      cyc("bp3", 1, 0, 1);
      cyc("bp_rel", 0, 0, 1);
      cyc("bp_rel2", 0, 0, 0);
      chk("bp.StallCnt", 32'(StallCnt), 32'd4);

      // Flush together with stall while the skid is full.
      cyc("fs_fill", 1, 0, 1);
      cyc("fs_flush", 1, 1, 1);
      chk("fs.FlushCnt", 32'(FlushCnt), 32'd1);
      chk("fs.StallCnt", 32'(StallCnt), 32'd5);
      cyc("fs_after", 0, 0, 0);

      // Asynchronous reset asserted mid-cycle with a valid word in Decode.
      cyc("pre_rst", 0, 0, 1);
      #1 rst_n = 1'b0;
      model_reset();
      #1 chk_reset_state("mid_rst");
      // Deassert during a stall; the first edge follows normal priority.
      release_reset(1'b1, 1'b0);
      cyc("rst_stall", 1, 0, 1);
      cyc("rst_adv", 0, 0, 1);

      // Saturation: 20 stall cycles, then idle bubbles past the limit.
      for (int i = 0; i < 20; i++) cyc("sat_stall", 1, 0, 0);
      chk("sat.StallCnt", 32'(StallCnt), 32'hF);
      for (int i = 0; i < 3; i++) cyc("sat_idle", 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc("sat_idle_st", 1, 0, 0);
      for (int i = 0; i < 16; i++) cyc("sat_bub", 0, 0, 0);
      chk("sat.BubbleCnt", 32'(BubbleCnt), 32'hF);

      // Random mix; reset first so counters are in range again.
      @(posedge clk);
      #1 rst_n = 1'b0;
      model_reset();
      release_reset(1'b0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         logic st, fl, vf;
         st = ($urandom_range(0, 99) < 35);
         fl = ($urandom_range(0, 99) < 6);
         vf = ($urandom_range(0, 99) < 75);
         cyc("rand", st, fl, vf);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
